// File: rtl/hgcal_input_packer.sv
// hgcal_input_packer: quantizes raw sensor-cell samples to Q_BITS codes and
// packs NUM_FEATURES of them into one flat registered frame for layer 0.
//
// Ports:
//   clk        rising-edge clock
//   rst        synchronous active-high reset
//   in_data    raw unsigned sample (IN_BITS)
//   in_valid   sample present
//   in_last    final sample of frame (checked only with INPUT_FRAME_CHECK_EN)
//   in_ready   packer accepts a sample this cycle (state decode, registered)
//   out_data   packed frame, feature i at [i*Q_BITS +: Q_BITS]
//   out_valid  frame held and stable
//   out_ready  layer-0 consumer takes the frame
//   frame_err  one-cycle pulse on a framing violation
//
// Optional feature: define INPUT_FRAME_CHECK_EN to check in_last against the
// beat count (adds the DRAIN state). Undefined: framing is by count only and
// frame_err is constant 0.
module hgcal_input_packer #(
   parameter int unsigned NUM_FEATURES = 48,
   parameter int unsigned IN_BITS      = 8,
   parameter int unsigned Q_BITS       = 2,
   parameter int unsigned SHIFT        = 6
) (
   input  logic                             clk,
   input  logic                             rst,
   input  logic [IN_BITS-1:0]               in_data,
   input  logic                             in_valid,
   input  logic                             in_last,
   output logic                             in_ready,
   output logic [NUM_FEATURES*Q_BITS-1:0]   out_data,
   output logic                             out_valid,
   input  logic                             out_ready,
   output logic                             frame_err
);

   localparam int unsigned CNT_W    = (NUM_FEATURES > 1) ? $clog2(NUM_FEATURES) : 1;
   localparam int unsigned OUT_W    = NUM_FEATURES * Q_BITS;
   localparam int unsigned Q_MAX    = (1 << Q_BITS) - 1;
   localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(NUM_FEATURES - 1);

`ifdef INPUT_FRAME_CHECK_EN
   typedef enum logic [1:0] {FILL = 2'd0, HOLD = 2'd1, DRAIN = 2'd2} state_e;
`else
   typedef enum logic {FILL = 1'b0, HOLD = 1'b1} state_e;
   // in_last carries no meaning when framing is by count only
   logic unused_in_last;
   assign unused_in_last = in_last;
`endif

   state_e             state_q, state_d;
   logic [CNT_W-1:0]   cnt_q, cnt_d;
   logic [OUT_W-1:0]   data_q, data_d;
   logic               out_valid_q, out_valid_d;
   logic               in_ready_q, in_ready_d;
   logic               err_q, err_d;

   logic [IN_BITS-1:0] shifted_c;
   logic [Q_BITS-1:0]  code_c;
   logic               accept_c;

   // Quantizer: shift then unsigned saturation to the largest Q_BITS code
   always_comb begin
      shifted_c = in_data >> SHIFT;
      if (32'(shifted_c) > Q_MAX) code_c = Q_BITS'(Q_MAX);
      else                        code_c = Q_BITS'(shifted_c);
   end

   assign accept_c = in_valid && in_ready_q;

   // Next-state, slot write and status flags
   always_comb begin
      state_d     = state_q;
      cnt_d       = cnt_q;
      data_d      = data_q;
      err_d       = 1'b0;
      case (state_q)
         FILL: begin
            if (accept_c) begin
`ifdef INPUT_FRAME_CHECK_EN
               if (in_last && (cnt_q != LAST_CNT)) begin
                  // early in_last: drop partial frame, restart filling
                  err_d = 1'b1;
                  cnt_d = '0;
               end else if (!in_last && (cnt_q == LAST_CNT)) begin
                  // frame overran its length: discard until next in_last
                  err_d   = 1'b1;
                  cnt_d   = '0;
                  state_d = DRAIN;
               end else
`endif
               begin
                  data_d[32'(cnt_q)*Q_BITS +: Q_BITS] = code_c;
                  if (cnt_q == LAST_CNT) begin
                     cnt_d   = '0;
                     state_d = HOLD;
                  end else begin
                     cnt_d = cnt_q + CNT_W'(1);
                  end
               end
            end
         end
         HOLD: begin
            if (out_ready) state_d = FILL;
         end
`ifdef INPUT_FRAME_CHECK_EN
         DRAIN: begin
            if (accept_c && in_last) begin
               cnt_d   = '0;
               state_d = FILL;
            end
         end
`endif
         default: state_d = FILL;
      endcase
      // handshake flags registered from the next state so they follow state only
      out_valid_d = (state_d == HOLD);
      in_ready_d  = (state_d != HOLD);
   end

   // State and datapath registers
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q     <= FILL;
         cnt_q       <= '0;
         data_q      <= '0;
         out_valid_q <= 1'b0;
         in_ready_q  <= 1'b1;
         err_q       <= 1'b0;
      end else begin
         state_q     <= state_d;
         cnt_q       <= cnt_d;
         data_q      <= data_d;
         out_valid_q <= out_valid_d;
         in_ready_q  <= in_ready_d;
         err_q       <= err_d;
      end
   end

   assign out_data  = data_q;
   assign out_valid = out_valid_q;
   assign in_ready  = in_ready_q;
   assign frame_err = err_q;

endmodule
